// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide requester and the unit it drives.
package muldiv_pkg;

  localparam int XLEN = 32;

  // RV32M funct3 codes, identical on both sides of the start/opcode handshake
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef logic [2:0] md_state_t;

  localparam md_state_t ST_IDLE  = 3'd0;
  localparam md_state_t ST_ISSUE = 3'd1;
  localparam md_state_t ST_WAIT  = 3'd2;
  localparam md_state_t ST_WB    = 3'd3;
  localparam md_state_t ST_DRAIN = 3'd4;

  function automatic logic op_is_divide(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Cycle watchdog for an outstanding multiply/divide op, with a sticky expiry flag.
module muldiv_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired,
  output logic err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Fires on the last allowed cycle so the owner leaves after exactly TIMEOUT_CYCLES cycles
  assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | expired;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Execute-stage controller that issues one M-extension op to the shared mul/div unit,
// stalls the pipeline while it is in flight, and performs the register writeback.
module muldiv_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            req_ready,
  input  logic            flush,
  output logic            stall,
  output logic            md_start,
  output logic [2:0]      md_opcode,
  output logic [XLEN-1:0] md_rs1,
  output logic [XLEN-1:0] md_rs2,
  input  logic            md_busy,
  input  logic            md_ready,
  input  logic [XLEN-1:0] md_result,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err_timeout
);

  import muldiv_pkg::*;

  md_state_t       state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] rs1_q, rs2_q, wb_data_q;
  logic [4:0]      rd_q;
  logic            accept;
  logic            wd_clear, wd_enable, wd_expired;

  assign req_ready = (state_q == ST_IDLE) && !md_busy;
  assign accept    = req_valid && req_ready && !flush;
  assign stall     = ((state_q != ST_IDLE) && (state_q != ST_WB)) ||
                     (req_valid && (state_q == ST_IDLE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      // The start pulse is already out, so a flush here must still wait for the unit
      ST_ISSUE: state_d = flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (md_ready)        state_d = flush ? ST_IDLE : ST_WB;
        else if (flush)      state_d = ST_DRAIN;
        else if (wd_expired) state_d = ST_IDLE;
      end
      ST_WB:    state_d = ST_IDLE;
      ST_DRAIN: if (md_ready || wd_expired) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign wd_enable = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign wd_clear  = ((state_d == ST_WAIT) || (state_d == ST_DRAIN)) && (state_d != state_q);

  muldiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired),
    .err    (err_timeout)
  );

  // Operands are captured once at accept and held until the next accept,
  // covering the unit's late operand read and its opcode read at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= req_funct3;
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
        rd_q  <= req_rd;
      end
      if ((state_q == ST_WAIT) && md_ready && !flush) begin
        wb_data_q <= md_result;
      end
    end
  end

  assign md_start  = (state_q == ST_ISSUE);
  assign md_opcode = op_q;
  assign md_rs1    = rs1_q;
  assign md_rs2    = rs2_q;
  assign wb_en     = (state_q == ST_WB) && (rd_q != 5'd0) && !flush;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a behavioural mul/div unit stub.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        flush;
  logic        stall;
  logic        md_start;
  logic [2:0]  md_opcode;
  logic [31:0] md_rs1, md_rs2;
  logic        md_busy;
  logic        md_ready;
  logic [31:0] md_result;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_issue_ctrl #(.TIMEOUT_CYCLES(64), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd(req_rd), .req_ready(req_ready), .flush(flush), .stall(stall),
    .md_start(md_start), .md_opcode(md_opcode), .md_rs1(md_rs1), .md_rs2(md_rs2),
    .md_busy(md_busy), .md_ready(md_ready), .md_result(md_result),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err_timeout(err_timeout)
  );

  // Unit stub: result one cycle after start for multiplies, three for divide-by-zero
  // and signed overflow, 35 for a normal divide. 'dead' suppresses completion.
  logic [5:0] u_cnt;
  logic       dead;
  logic       busy_force;

  function automatic logic [5:0] lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 6'd1;
    if (b == 32'd0) return 6'd3;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 6'd3;
    return 6'd35;
  endfunction

  function automatic logic [31:0] unit_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic               ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      OP_MULH:   begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
      OP_MULHSU: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return ps[63:32]; end
      OP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)                u_cnt <= 6'd0;
    else if (md_start)      u_cnt <= lat_of(md_opcode, md_rs1, md_rs2);
    else if (u_cnt != 6'd0) u_cnt <= u_cnt - 6'd1;
  end

  assign md_ready  = (u_cnt == 6'd1) && !dead;
  assign md_busy   = (u_cnt > 6'd1) || busy_force;
  assign md_result = md_ready ? unit_calc(md_opcode, md_rs1, md_rs2) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    int          exp_lat;   // 0: no writeback expected
  } vec_t;

  vec_t vt[12];

  task automatic run_vec(input vec_t v, input int idx);
    int starts = 0, start_cyc = 0, lat = 0;
    bit stable = 1'b1, got = 1'b0;
    logic [4:0]  got_rd = '0;
    logic [31:0] got_data = '0;
    logic        got_stall = 1'b1;
    req_funct3 = v.f3; req_rs1 = v.a; req_rs2 = v.b; req_rd = v.rd; req_valid = 1'b1;
    #1;
    chk($sformatf("v%0d_req_ready", idx), {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0; req_rs1 = 32'hA5A5_A5A5; req_rs2 = 32'h5A5A_5A5A; req_funct3 = ~v.f3;
    for (int c = 1; c <= 45 && !got; c++) begin
      if (md_start) begin starts++; start_cyc = c; end
      if (md_opcode !== v.f3 || md_rs1 !== v.a || md_rs2 !== v.b) stable = 1'b0;
      if (wb_en) begin
        got = 1'b1; lat = c; got_rd = wb_rd; got_data = wb_data; got_stall = stall;
      end else begin
        step();
      end
    end
    chk($sformatf("v%0d_start_count", idx), 32'(starts), 32'd1);
    chk($sformatf("v%0d_start_cycle", idx), 32'(start_cyc), 32'd1);
    chk($sformatf("v%0d_operands_stable", idx), {31'b0, stable}, 32'd1);
    if (v.exp_lat > 0) begin
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_wb_rd", idx), {27'b0, got_rd}, {27'b0, v.rd});
      chk($sformatf("v%0d_wb_data", idx), got_data, v.exp_data);
      chk($sformatf("v%0d_wb_stall", idx), {31'b0, got_stall}, 32'd0);
      step();
      chk($sformatf("v%0d_wb_one_cycle", idx), {31'b0, wb_en}, 32'd0);
    end else begin
      chk($sformatf("v%0d_no_wb", idx), {31'b0, got}, 32'd0);
    end
    chk($sformatf("v%0d_idle_after", idx), {31'b0, req_ready}, 32'd1);
  endtask

  task automatic flush_seq(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input int fat, input int tot, input bit chk_stall);
    int wbn = 0, stall_low = 0;
    req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = 5'd7; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c < tot; c++) begin
      flush = (c == fat);
      #1;
      if (wb_en) wbn++;
      if (!stall) stall_low++;
      step();
    end
    flush = 1'b0;
    #1;
    chk({nm, "_no_wb"}, 32'(wbn), 32'd0);
    chk({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
    if (chk_stall) chk({nm, "_stall_held"}, 32'(stall_low), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{OP_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         3};
    vt[1]  = '{OP_MULH,   32'hFFFF_FFFF,  32'd2,          5'd1,  32'hFFFF_FFFF,  3};
    vt[2]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFF,  3};
    vt[3]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'd2,          5'd3,  32'd1,          3};
    vt[4]  = '{OP_DIV,    32'hFFFF_FFEC,  32'd3,          5'd9,  32'hFFFF_FFFA,  37};
    vt[5]  = '{OP_REM,    32'hFFFF_FFEC,  32'd3,          5'd10, 32'hFFFF_FFFE,  37};
    vt[6]  = '{OP_DIVU,   32'h0000_1234,  32'd0,          5'd11, 32'hFFFF_FFFF,  5};
    vt[7]  = '{OP_REMU,   32'h0000_1234,  32'd0,          5'd12, 32'h0000_1234,  5};
    vt[8]  = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  5};
    vt[9]  = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          5};
    vt[10] = '{OP_DIVU,   32'd100,        32'd7,          5'd15, 32'd14,         37};
    vt[11] = '{OP_MUL,    32'd3,          32'd4,          5'd0,  32'd0,          0};

    rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    flush = 1'b0; dead = 1'b0; busy_force = 1'b0;
    step(); step();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_outputs", {28'b0, md_start, wb_en, err_timeout, stall}, 32'd0);
    chk("rst_md_opcode", {29'b0, md_opcode}, 32'd0);
    chk("rst_md_rs1", md_rs1, 32'd0);
    chk("rst_md_rs2", md_rs2, 32'd0);
    chk("rst_wb", {27'b0, wb_rd} | wb_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // Unit busy blocks acceptance; the pending request still stalls decode
    busy_force = 1'b1; req_funct3 = OP_MUL; req_rs1 = 32'd1; req_rs2 = 32'd1; req_rd = 5'd1;
    req_valid = 1'b1;
    #1;
    chk("busy_req_ready", {31'b0, req_ready}, 32'd0);
    chk("busy_stall", {31'b0, stall}, 32'd1);
    step();
    busy_force = 1'b0; req_valid = 1'b0;
    #1;
    chk("busy_no_start", {31'b0, md_start}, 32'd0);

    // Flush in IDLE rejects the request
    req_valid = 1'b1; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("idle_flush_no_start", {31'b0, md_start}, 32'd0);
    chk("idle_flush_ready", {31'b0, req_ready}, 32'd1);

    flush_seq("div_flush10", OP_DIV, 32'hFFFF_FFEC, 32'd3, 10, 37, 1'b1);
    flush_seq("mul_flush_issue", OP_MUL, 32'd5, 32'd5, 1, 3, 1'b1);
    flush_seq("mul_flush_ready", OP_MUL, 32'd5, 32'd5, 2, 3, 1'b1);
    flush_seq("mul_flush_wb", OP_MUL, 32'd5, 32'd5, 3, 4, 1'b0);

    // Watchdog: unit never completes
    begin
      int wbn = 0;
      dead = 1'b1;
      req_funct3 = OP_MUL; req_rs1 = 32'd2; req_rs2 = 32'd3; req_rd = 5'd4; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int c = 1; c < 65; c++) begin
        if (wb_en) wbn++;
        step();
      end
      chk("wd_err_before", {31'b0, err_timeout}, 32'd0);
      chk("wd_busy_before", {31'b0, req_ready}, 32'd0);
      step();
      chk("wd_err_set", {31'b0, err_timeout}, 32'd1);
      chk("wd_idle", {31'b0, req_ready}, 32'd1);
      chk("wd_no_wb", 32'(wbn), 32'd0);
      dead = 1'b0;
    end
    run_vec(vt[0], 100);
    chk("wd_err_sticky", {31'b0, err_timeout}, 32'd1);

    // Asynchronous reset in the middle of a divide
    req_funct3 = OP_DIV; req_rs1 = 32'hFFFF_FFEC; req_rs2 = 32'd3; req_rd = 5'd9; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c < 20; c++) step();
    chk("rst_mid_pre_rs1", md_rs1, 32'hFFFF_FFEC);
    chk("rst_mid_pre_stall", {31'b0, stall}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_rs", md_rs1 | md_rs2, 32'd0);
    chk("rst_mid_ctrl", {27'b0, md_opcode, md_start, stall}, 32'd0);
    chk("rst_mid_wb_err", {25'b0, wb_rd, wb_en, err_timeout}, 32'd0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    step();
    run_vec(vt[3], 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
